lsu_mem_adapter: RTL and testbench
==================================

// Module: lsu_mem_adapter
// PURPOSE
//  Load/store adapter that sits directly upstream of the word-only data memory.
//  Takes CPU load/store requests (byte/half/word, RV32I funct3 encoding) over a valid/ready handshake.
//  Turns them into memory accesses: word-aligned, base-relative, one-cycle read latency, no byte strobes.
//  Sub-word stores become read-modify-write; load data is extracted and sign/zero-extended.
// PARAMETERS
//  BASE_ADDR  32'h80000000  first byte address mapped to memory word 0
//  END_ADDR   32'hA0000000  first byte address past the end of memory
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   synchronous, active-high reset
//  req_valid_i  in   1   request valid
//  req_ready_o  out  1   request accepted when valid&ready
//  req_we_i     in   1   1=store, 0=load
//  req_funct3_i in   3   loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores: 0 SB, 1 SH, 2 SW
//  req_addr_i   in   32  byte address
//  req_wdata_i  in   32  store data; low byte/half used for SB/SH
//  rsp_valid_o  out  1   response valid, held until rsp_ready_i
//  rsp_ready_i  in   1   response consumed when valid&ready
//  rsp_rdata_o  out  32  extended load data; 0 for stores and errors
//  rsp_err_o    out  1   misaligned, out-of-range or illegal funct3
//  mem_en_o     out  1   memory enable
//  mem_we_o     out  1   memory write enable
//  mem_addr_o   out  32  (addr - BASE_ADDR) & ~3
//  mem_wdata_o  out  32  word to write
//  mem_rdata_i  in   32  registered memory read data, valid 1 cycle after en&!we
// BEHAVIOUR
//  Reset: state IDLE; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_en_o=0, mem_we_o=0.
//  - mem_addr_o=0, mem_wdata_o=0; req_ready_o=1 in the first cycle after reset.
//  States: IDLE, RD, LD_CAP, WR, RMW_MRG, RSP.
//  - req_ready_o=1 only in IDLE.
//  - mem_en_o/mem_we_o are decoded combinationally from state; all request fields are registered on accept.
//  Accept at edge T (IDLE, valid&ready). Request checks:
//  - Error if funct3 is illegal for the direction.
//  - Error if half is not 2-aligned or word is not 4-aligned.
//  - Error if addr < BASE_ADDR or addr+size > END_ADDR.
//  - On error: go to RSP with err=1, rdata=0; no memory access ever issued.
//  Load: RD (en=1, we=0) -> LD_CAP.
//  - LD_CAP: pick the byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  - Register the result into rsp_rdata_o -> RSP.
//  - rsp_valid_o first high in cycle T+3.
//  SW: WR (en=1, we=1, wdata=req_wdata) -> RSP; rsp_valid_o first high in cycle T+2.
//  SB/SH: RD (en=1, we=0) -> RMW_MRG.
//  - RMW_MRG: en=1, we=1, wdata = mem_rdata_i with the target lane replaced.
//  - Byte lane = addr[1:0]; half lane = addr[1]. Then -> RSP.
//  - rsp_valid_o first high in cycle T+3; exactly one write pulse.
//  RSP: hold rsp_* stable while rsp_ready_i=0.
//  - On valid&ready -> IDLE; req_ready_o=1 in the next cycle.
//  - rsp_valid_o drops the cycle after the handshake.
//  mem_en_o=0 in IDLE and RSP. The memory then zeroes its read data; the block must not sample it there.
//  Exactly one memory access per phase; addresses never wrap.
//  - addr+size is computed 33-bit wide, so an access at 32'hFFFFFFFF is an error, not a wrap.
//  Reset in any state: IDLE on the next edge, pending response dropped.
//  - Reset in RD of an RMW: no write is issued.
//  - Reset in RMW_MRG/WR: the write issued that cycle may land; no response.
//  req_valid_i while busy: ignored (not accepted); the requester must hold it.
// TESTING
//  1. mem word @0x80000010 = 0xDEADBEEF.
//     - LW 0x80000010 -> mem_addr_o=0x10 at T+1; rsp rdata=0xDEADBEEF, err=0 at T+3.
//  2. Same word:
//     - LB 0x80000013 -> 0xFFFFFFDE; LBU -> 0x000000DE.
//     - LH 0x80000012 -> 0xFFFFDEAD; LHU 0x80000010 -> 0x0000BEEF.
//  3. word @0x80000020 = 0x11223344; SB 0x80000021 data 0xAB.
//     - One read at T+1, one write at T+2 with wdata 0x1122AB44; rsp at T+3.
//  4. SH 0x80000001, LW 0x80000002, LW 0x7FFFFFFC, SW 0x9FFFFFFE, funct3=3 load.
//     - Each gives rsp err=1 at T+1; mem_en_o never asserted.
//  5. rsp_ready_i low 4 cycles after a load.
//     - rsp_valid_o/rdata stable; req_ready_o=0; second request accepted only after the handshake.
//  6. rst_i pulsed in RD of an SB.
//     - No mem_we_o pulse; rsp_valid_o=0; req_ready_o=1 the cycle after reset is released.

Source files
------------

// File: rtl/lsu_mem_adapter_if.sv
// lsu_mem_adapter_if: request/response handshake and word-memory bus of the load/store adapter
interface lsu_mem_adapter_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter: turns byte/half/word CPU loads and stores into word-only memory accesses
module lsu_mem_adapter #(
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter logic [31:0] END_ADDR  = 32'hA0000000
) (
    input logic               clk_i,
    input logic               rst_i,
    lsu_mem_adapter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, LD_CAP, WR, RMW_MRG, RSP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [2:0]  size;
    logic        legal, misal, oor, bad;
    logic [31:0] sh, ext, mask, lane_data, merged;

    // Request checks on the incoming fields; the limit sum is 33 bits so the top of the address space cannot wrap
    always_comb begin
        size  = bus.req_funct3_i[1:0] == 2'd0 ? 3'd1 : bus.req_funct3_i[1:0] == 2'd1 ? 3'd2 : 3'd4;
        legal = bus.req_we_i ? (!bus.req_funct3_i[2] && bus.req_funct3_i[1:0] != 2'd3)
                             : (bus.req_funct3_i[1:0] != 2'd3 && bus.req_funct3_i != 3'd6);
        misal = (size == 3'd2 && bus.req_addr_i[0]) || (size == 3'd4 && |bus.req_addr_i[1:0]);
        oor   = bus.req_addr_i < BASE_ADDR || ({1'b0, bus.req_addr_i} + {30'b0, size}) > {1'b0, END_ADDR};
        bad   = !legal || misal || oor;
    end

    // Lane extraction for loads and lane replacement for sub-word stores, both from the word read last cycle
    always_comb begin
        sh        = bus.mem_rdata_i >> {lane_q, 3'b000};
        ext       = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]}
                  : f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
        mask      = f3_q[0] ? 32'h0000FFFF << {lane_q, 3'b000} : 32'h000000FF << {lane_q, 3'b000};
        lane_data = f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
        merged    = (bus.mem_rdata_i & ~mask) | (lane_data & mask);
    end

    // Next-state and next-field computation of the access sequencer
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.req_valid_i) begin
                we_d    = bus.req_we_i;
                f3_d    = bus.req_funct3_i;
                lane_d  = bus.req_addr_i[1:0];
                off_d   = (bus.req_addr_i - BASE_ADDR) & ~32'd3;
                wdata_d = bus.req_wdata_i;
                rdata_d = '0;
                err_d   = bad;
                state_d = bad ? RSP : (bus.req_we_i && bus.req_funct3_i[1:0] == 2'd2) ? WR : RD;
            end
            RD:      state_d = we_q ? RMW_MRG : LD_CAP;
            LD_CAP:  begin
                rdata_d = ext;
                state_d = RSP;
            end
            WR:      state_d = RSP;
            RMW_MRG: state_d = RSP;
            RSP:     if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request-field registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            lane_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready_o = state_q == IDLE;
    assign bus.rsp_valid_o = state_q == RSP;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.mem_en_o    = state_q == RD || state_q == WR || state_q == RMW_MRG;
    assign bus.mem_we_o    = state_q == WR || state_q == RMW_MRG;
    assign bus.mem_addr_o  = off_q;
    assign bus.mem_wdata_o = state_q == WR ? wdata_q : state_q == RMW_MRG ? merged : '0;
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// tb_lsu_mem_adapter: table-driven check of the load/store adapter against a word memory model
module tb_lsu_mem_adapter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    lsu_mem_adapter_if ifc();

    lsu_mem_adapter dut (.clk_i(clk_i), .rst_i(rst_i), .bus(ifc.slave));

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [31:0] mwd;
    } vec_t;

    logic [31:0] mem [256];
    logic [31:0] mem_rd_q = '0;
    int en_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] last_wd = '0;
    int total = 0;
    int bad = 0;
    vec_t vt [$];

    assign ifc.mem_rdata_i = mem_rd_q;

    // Word memory with one-cycle registered read; read data is zero whenever the memory is idle
    always_ff @(posedge clk_i) begin
        if (ifc.mem_en_o) begin
            if (ifc.mem_we_o) mem[ifc.mem_addr_o[9:2]] <= ifc.mem_wdata_o;
            mem_rd_q <= ifc.mem_we_o ? '0 : mem[ifc.mem_addr_o[9:2]];
            en_cnt <= en_cnt + 1;
            if (ifc.mem_we_o) begin
                wr_cnt  <= wr_cnt + 1;
                last_wd <= ifc.mem_wdata_o;
            end
        end else begin
            mem_rd_q <= '0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input logic err,
                                input logic [31:0] mwd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.err = err; v.mwd = mwd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ifc.req_valid_i  = 1'b1;
        ifc.req_we_i     = v.we;
        ifc.req_funct3_i = v.f3;
        ifc.req_addr_i   = v.addr;
        ifc.req_wdata_i  = v.wd;
    endtask

    task automatic xfer(input vec_t v, input string nm);
        int lat, en0, wr0, exp_lat, exp_en;
        en0 = en_cnt;
        wr0 = wr_cnt;
        exp_lat = v.err ? 1 : (v.we && v.f3 == 3'd2) ? 2 : 3;
        exp_en  = v.err ? 0 : (v.we && v.f3 != 3'd2) ? 2 : 1;
        @(negedge clk_i);
        drive(v);
        chk({nm, " req_ready"}, 32'(ifc.req_ready_o), 32'd1);
        @(negedge clk_i);
        ifc.req_valid_i = 1'b0;
        lat = 1;
        if (!v.err) chk({nm, " mem_addr"}, ifc.mem_addr_o, (v.addr - 32'h80000000) & ~32'd3);
        while (!ifc.rsp_valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " rdata"}, ifc.rsp_rdata_o, v.rd);
        chk({nm, " err"}, 32'(ifc.rsp_err_o), 32'(v.err));
        @(negedge clk_i);
        chk({nm, " rsp_drop"}, 32'(ifc.rsp_valid_o), 32'd0);
        chk({nm, " mem_en_cycles"}, 32'(en_cnt - en0), 32'(exp_en));
        chk({nm, " writes"}, 32'(wr_cnt - wr0), (v.we && !v.err) ? 32'd1 : 32'd0);
        if (v.we && !v.err) chk({nm, " write_data"}, last_wd, v.mwd);
    endtask

    initial begin
        int lat, en0, wr0;
        vt.push_back(mk(1, 3'd2, 32'h80000010, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF));
        vt.push_back(mk(1, 3'd2, 32'h80000020, 32'h11223344, 32'h0, 0, 32'h11223344));
        vt.push_back(mk(0, 3'd2, 32'h80000010, 32'h0, 32'hDEADBEEF, 0, 32'h0));
        vt.push_back(mk(0, 3'd0, 32'h80000013, 32'h0, 32'hFFFFFFDE, 0, 32'h0));
        vt.push_back(mk(0, 3'd4, 32'h80000013, 32'h0, 32'h000000DE, 0, 32'h0));
        vt.push_back(mk(0, 3'd1, 32'h80000012, 32'h0, 32'hFFFFDEAD, 0, 32'h0));
        vt.push_back(mk(0, 3'd5, 32'h80000010, 32'h0, 32'h0000BEEF, 0, 32'h0));
        vt.push_back(mk(1, 3'd0, 32'h80000021, 32'hFFFFFFAB, 32'h0, 0, 32'h1122AB44));
        vt.push_back(mk(0, 3'd2, 32'h80000020, 32'h0, 32'h1122AB44, 0, 32'h0));
        vt.push_back(mk(1, 3'd1, 32'h80000022, 32'hABCD5566, 32'h0, 0, 32'h5566AB44));
        vt.push_back(mk(0, 3'd0, 32'h80000011, 32'h0, 32'hFFFFFFBE, 0, 32'h0));
        vt.push_back(mk(0, 3'd4, 32'h80000010, 32'h0, 32'h000000EF, 0, 32'h0));
        vt.push_back(mk(0, 3'd1, 32'h80000010, 32'h0, 32'hFFFFBEEF, 0, 32'h0));
        vt.push_back(mk(1, 3'd2, 32'h9FFFFFFC, 32'h12345678, 32'h0, 0, 32'h12345678));
        vt.push_back(mk(0, 3'd2, 32'h9FFFFFFC, 32'h0, 32'h12345678, 0, 32'h0));
        vt.push_back(mk(0, 3'd4, 32'h9FFFFFFF, 32'h0, 32'h00000012, 0, 32'h0));
        vt.push_back(mk(1, 3'd1, 32'h80000001, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(0, 3'd2, 32'h80000002, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(0, 3'd2, 32'h7FFFFFFC, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(1, 3'd2, 32'h9FFFFFFE, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(0, 3'd3, 32'h80000010, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(0, 3'd6, 32'h80000010, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(1, 3'd4, 32'h80000010, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(0, 3'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 32'h0));
        vt.push_back(mk(0, 3'd2, 32'hA0000000, 32'h0, 32'h0, 1, 32'h0));

        ifc.req_valid_i  = 1'b0;
        ifc.req_we_i     = 1'b0;
        ifc.req_funct3_i = '0;
        ifc.req_addr_i   = '0;
        ifc.req_wdata_i  = '0;
        ifc.rsp_ready_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst req_ready", 32'(ifc.req_ready_o), 32'd1);
        chk("rst rsp_valid", 32'(ifc.rsp_valid_o), 32'd0);
        chk("rst rsp_err", 32'(ifc.rsp_err_o), 32'd0);
        chk("rst rsp_rdata", ifc.rsp_rdata_o, 32'd0);
        chk("rst mem_en", 32'(ifc.mem_en_o), 32'd0);
        chk("rst mem_we", 32'(ifc.mem_we_o), 32'd0);
        chk("rst mem_addr", ifc.mem_addr_o, 32'd0);
        chk("rst mem_wdata", ifc.mem_wdata_o, 32'd0);

        foreach (vt[i]) xfer(vt[i], $sformatf("vec%0d", i));

        // Response back-pressure with a second request held during the stall
        @(negedge clk_i);
        ifc.rsp_ready_i = 1'b0;
        drive(mk(0, 3'd2, 32'h80000010, 32'h0, 32'h0, 0, 32'h0));
        @(negedge clk_i);
        drive(mk(0, 3'd2, 32'h80000020, 32'h0, 32'h0, 0, 32'h0));
        lat = 1;
        while (!ifc.rsp_valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        chk("bp latency", 32'(lat), 32'd3);
        en0 = en_cnt;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp hold%0d valid", k), 32'(ifc.rsp_valid_o), 32'd1);
            chk($sformatf("bp hold%0d rdata", k), ifc.rsp_rdata_o, 32'hDEADBEEF);
            chk($sformatf("bp hold%0d req_ready", k), 32'(ifc.req_ready_o), 32'd0);
            @(negedge clk_i);
        end
        chk("bp no_access", 32'(en_cnt - en0), 32'd0);
        chk("bp still_valid", 32'(ifc.rsp_valid_o), 32'd1);
        ifc.rsp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp drop", 32'(ifc.rsp_valid_o), 32'd0);
        chk("bp ready_after", 32'(ifc.req_ready_o), 32'd1);
        @(negedge clk_i);
        ifc.req_valid_i = 1'b0;
        lat = 1;
        while (!ifc.rsp_valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        chk("bp second latency", 32'(lat), 32'd3);
        chk("bp second rdata", ifc.rsp_rdata_o, 32'h5566AB44);
        @(negedge clk_i);

        // Reset while the read phase of a byte store is in flight
        wr0 = wr_cnt;
        drive(mk(1, 3'd0, 32'h80000020, 32'h00000077, 32'h0, 0, 32'h0));
        chk("rstrmw req_ready", 32'(ifc.req_ready_o), 32'd1);
        @(negedge clk_i);
        ifc.req_valid_i = 1'b0;
        chk("rstrmw in_rd en", 32'(ifc.mem_en_o), 32'd1);
        chk("rstrmw in_rd we", 32'(ifc.mem_we_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rstrmw rsp_valid", 32'(ifc.rsp_valid_o), 32'd0);
        @(negedge clk_i);
        chk("rstrmw req_ready", 32'(ifc.req_ready_o), 32'd1);
        chk("rstrmw rsp_valid2", 32'(ifc.rsp_valid_o), 32'd0);
        chk("rstrmw no_write", 32'(wr_cnt - wr0), 32'd0);
        xfer(mk(0, 3'd2, 32'h80000020, 32'h0, 32'h5566AB44, 0, 32'h0), "rstrmw readback");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
